snd_mailbox: RTL and testbench

- Parametrised bidirectional mailbox between the 68k main CPU and the 6502 sound CPU. It replaces the single-byte 374/74 latch-and-flag pair with two first-word-fall-through FIFOs.
- Main→sound traffic raises the sound NMI. Sound→main traffic raises the 68k sound interrupt.
- Sits on the sound data bus, decoded by the existing 138 outputs (WR68k/RD68k on the sound side; SNDWR/SNDRD on the main side).

---
 rtl/snd_mailbox_pkg.sv | 19 +
 rtl/snd_mailbox_fifo.sv | 113 +++++++++++
 rtl/snd_mailbox.sv | 123 ++++++++++++
 tb/tb_snd_mailbox.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/snd_mailbox_pkg.sv
// Shared types and sizing helpers for the main/sound CPU mailbox.
// Optional status block is enabled with SNDMBX_STATUS_EN.
package snd_mailbox_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_NMI_GAP = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } nmi_state_e;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/snd_mailbox_fifo.sv
// One mailbox direction: strobe edge detect, holding latch and FWFT FIFO.
// SNDMBX_STATUS_EN adds occupancy count and sticky overflow/underflow flags.
module snd_mailbox_fifo
  import snd_mailbox_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_b,
  input  logic             rd_b,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             pop_ok
`ifdef SNDMBX_STATUS_EN
  ,
  input  logic                 stat_clr_b,
  output logic [ptr_w(DEPTH):0] count,
  output logic                 ovf,
  output logic                 unf
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic             wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_req, pop_req, do_push, do_pop;

  // Operations commit on the strobe's deassert edge, like the old 374 latch.
  assign push_req = !wr_prev_q && wr_b;
  assign pop_req  = !rd_prev_q && rd_b;

  always_comb begin
    wr_prev_d = wr_b;
    rd_prev_d = rd_b;
    hold_d    = wr_b ? hold_q : din;
    do_pop    = pop_req && (count_q != '0);
    do_push   = push_req && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d  = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
    dout_d = dout_q;
    // The new head may be the entry being written this very cycle.
    if (count_d != '0)
      dout_d = (do_push && (rd_ptr_d == wr_ptr_q)) ? hold_q : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    if (do_push) mem_q[wr_ptr_q] <= hold_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_prev_q <= 1'b1;
      rd_prev_q <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dout_q    <= '0;
    end else begin
      wr_prev_q <= wr_prev_d;
      rd_prev_q <= rd_prev_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
    end
  end

  assign dout   = dout_q;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign pop_ok = do_pop;

`ifdef SNDMBX_STATUS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // A new event in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = stat_clr_b ? ovf_q : 1'b0;
    unf_d = stat_clr_b ? unf_q : 1'b0;
    if (push_req && !do_push) ovf_d = 1'b1;
    if (pop_req && !do_pop)   unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
`endif

endmodule

// File: rtl/snd_mailbox.sv
// Bidirectional 68k <-> 6502 mailbox: two FIFOs, sound NMI sequencer, 68k interrupt.
// Define SNDMBX_STATUS_EN to expose counts and sticky overflow/underflow status.
module snd_mailbox
  import snd_mailbox_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NMI_GAP = DEF_NMI_GAP
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] main_din,
  input  logic             main_wr_b,
  input  logic             main_rd_b,
  output logic [WIDTH-1:0] main_dout,
  output logic             main_int_b,
  input  logic [WIDTH-1:0] snd_din,
  input  logic             snd_wr_b,
  input  logic             snd_rd_b,
  output logic [WIDTH-1:0] snd_dout,
  output logic             snd_nmi_b,
  output logic             m2s_full,
  output logic             m2s_empty,
  output logic             s2m_full,
  output logic             s2m_empty
`ifdef SNDMBX_STATUS_EN
  ,
  output logic [ptr_w(DEPTH):0] m2s_count,
  output logic [ptr_w(DEPTH):0] s2m_count,
  output logic                  m2s_ovf,
  output logic                  s2m_ovf,
  output logic                  m2s_unf,
  output logic                  s2m_unf,
  input  logic                  stat_clr_b
`endif
);

  localparam int GW = (NMI_GAP > 1) ? $clog2(NMI_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(NMI_GAP - 1);

  logic [1:0]  rst_sync_q, rst_sync_d;
  logic        rst_int_b;
  logic        m2s_pop, s2m_pop_unused;
  logic        main_int_q, main_int_d;
  nmi_state_e  state_q;
  logic        nmi_b_q;
  logic [GW-1:0] gap_cnt_q;

  // Reset asserts asynchronously everywhere but releases two clocks later.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    main_int_d = s2m_empty;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_b = rst_sync_q[1];

  snd_mailbox_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_m2s (
    .clk(clk), .rst_b(rst_int_b), .din(main_din), .wr_b(main_wr_b), .rd_b(snd_rd_b),
    .dout(snd_dout), .full(m2s_full), .empty(m2s_empty), .pop_ok(m2s_pop)
`ifdef SNDMBX_STATUS_EN
    , .stat_clr_b(stat_clr_b), .count(m2s_count), .ovf(m2s_ovf), .unf(m2s_unf)
`endif
  );

  snd_mailbox_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_s2m (
    .clk(clk), .rst_b(rst_int_b), .din(snd_din), .wr_b(snd_wr_b), .rd_b(main_rd_b),
    .dout(main_dout), .full(s2m_full), .empty(s2m_empty), .pop_ok(s2m_pop_unused)
`ifdef SNDMBX_STATUS_EN
    , .stat_clr_b(stat_clr_b), .count(s2m_count), .ovf(s2m_ovf), .unf(s2m_unf)
`endif
  );

  always_ff @(posedge clk or negedge rst_int_b) begin
    if (!rst_int_b) main_int_q <= 1'b1;
    else            main_int_q <= main_int_d;
  end

  // Each queued byte gets its own NMI falling edge, separated by a forced-high gap.
  always_ff @(posedge clk or negedge rst_int_b) begin
    if (!rst_int_b) begin
      state_q   <= ST_IDLE;
      nmi_b_q   <= 1'b1;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!m2s_empty) begin
            state_q <= ST_ASSERT;
            nmi_b_q <= 1'b0;
          end
        end
        ST_ASSERT: begin
          if (m2s_pop || m2s_empty) begin
            state_q   <= ST_GAP;
            nmi_b_q   <= 1'b1;
            gap_cnt_q <= '0;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= m2s_empty ? ST_IDLE : ST_ASSERT;
            nmi_b_q <= m2s_empty;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          nmi_b_q <= 1'b1;
        end
      endcase
    end
  end

  assign main_int_b = main_int_q;
  assign snd_nmi_b  = nmi_b_q;

endmodule

// File: tb/tb_snd_mailbox.sv
// Self-checking bench for snd_mailbox against a queue-based mailbox model.
// Status checks are compiled in when SNDMBX_STATUS_EN is defined.
module tb_snd_mailbox;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int NMI_GAP = 2;

  logic clk, rst_b;
  logic [7:0] main_din, main_dout, snd_din, snd_dout;
  logic main_wr_b, main_rd_b, main_int_b, snd_wr_b, snd_rd_b, snd_nmi_b;
  logic m2s_full, m2s_empty, s2m_full, s2m_empty;
`ifdef SNDMBX_STATUS_EN
  logic [2:0] m2s_count, s2m_count;
  logic m2s_ovf, s2m_ovf, m2s_unf, s2m_unf, stat_clr_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] m2s_q[$];
  logic [7:0] s2m_q[$];
  logic [7:0] m2s_last = 8'h00;
  logic [7:0] s2m_last = 8'h00;

  snd_mailbox #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NMI_GAP(NMI_GAP)) dut (
    .clk(clk), .rst_b(rst_b),
    .main_din(main_din), .main_wr_b(main_wr_b), .main_rd_b(main_rd_b),
    .main_dout(main_dout), .main_int_b(main_int_b),
    .snd_din(snd_din), .snd_wr_b(snd_wr_b), .snd_rd_b(snd_rd_b),
    .snd_dout(snd_dout), .snd_nmi_b(snd_nmi_b),
    .m2s_full(m2s_full), .m2s_empty(m2s_empty), .s2m_full(s2m_full), .s2m_empty(s2m_empty)
`ifdef SNDMBX_STATUS_EN
    , .m2s_count(m2s_count), .s2m_count(s2m_count), .m2s_ovf(m2s_ovf), .s2m_ovf(s2m_ovf),
    .m2s_unf(m2s_unf), .s2m_unf(s2m_unf), .stat_clr_b(stat_clr_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a mailbox is a bounded queue; the visible head is the oldest entry,
  // or the last value shown once the queue drains.
  task automatic model_op(input int which, input logic [7:0] d);
    case (which)
      0: if (m2s_q.size() < DEPTH) m2s_q.push_back(d);
      1: if (s2m_q.size() < DEPTH) s2m_q.push_back(d);
      2: if (s2m_q.size() > 0) void'(s2m_q.pop_front());
      default: if (m2s_q.size() > 0) void'(m2s_q.pop_front());
    endcase
    if (m2s_q.size() > 0) m2s_last = m2s_q[0];
    if (s2m_q.size() > 0) s2m_last = s2m_q[0];
  endtask

  // which: 0 main write, 1 sound write, 2 main read, 3 sound read.
  task automatic strobe(input int which, input logic [7:0] d, input int hold);
    @(negedge clk);
    case (which)
      0: begin main_din = d; main_wr_b = 1'b0; end
      1: begin snd_din = d; snd_wr_b = 1'b0; end
      2: main_rd_b = 1'b0;
      default: snd_rd_b = 1'b0;
    endcase
    repeat (hold) @(negedge clk);
    main_wr_b = 1'b1; snd_wr_b = 1'b1; main_rd_b = 1'b1; snd_rd_b = 1'b1;
    @(negedge clk);
    model_op(which, d);
  endtask

  task automatic test_reset();
    #23;
    vectors++; if (m2s_empty !== 1'b1) begin miscompares++; $display("FAIL reset_m2s_empty got %b want 1", m2s_empty); end
    vectors++; if (s2m_empty !== 1'b1) begin miscompares++; $display("FAIL reset_s2m_empty got %b want 1", s2m_empty); end
    vectors++; if ({m2s_full, s2m_full} !== 2'b00) begin miscompares++; $display("FAIL reset_full got %b want 00", {m2s_full, s2m_full}); end
    vectors++; if ({snd_nmi_b, main_int_b} !== 2'b11) begin miscompares++; $display("FAIL reset_irq got %b want 11", {snd_nmi_b, main_int_b}); end
    @(negedge clk); rst_b = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if ({snd_dout, main_dout} !== 16'h0000) begin miscompares++; $display("FAIL reset_dout got %h want 0000", {snd_dout, main_dout}); end
    vectors++; if ({snd_nmi_b, main_int_b, m2s_empty, s2m_empty} !== 4'b1111) begin miscompares++; $display("FAIL post_reset_flags got %b want 1111", {snd_nmi_b, main_int_b, m2s_empty, s2m_empty}); end
  endtask

  task automatic test_first_push();
    @(negedge clk); main_din = 8'hA5; main_wr_b = 1'b0;
    repeat (3) @(negedge clk);
    main_wr_b = 1'b1;
    @(negedge clk);
    model_op(0, 8'hA5);
    vectors++; if (m2s_empty !== 1'b0) begin miscompares++; $display("FAIL first_empty got %b want 0", m2s_empty); end
    vectors++; if (snd_dout !== 8'hA5) begin miscompares++; $display("FAIL first_dout got %h want a5", snd_dout); end
    vectors++; if (snd_nmi_b !== 1'b1) begin miscompares++; $display("FAIL first_nmi_early got %b want 1", snd_nmi_b); end
    @(negedge clk);
    vectors++; if (snd_nmi_b !== 1'b0) begin miscompares++; $display("FAIL first_nmi got %b want 0", snd_nmi_b); end
    strobe(3, 8'h00, 1);
    vectors++; if ({m2s_empty, snd_dout} !== {1'b1, 8'hA5}) begin miscompares++; $display("FAIL first_drain got %b/%h want 1/a5", m2s_empty, snd_dout); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_nmi_gap();
    int hi, exp_hi;
    for (int i = 1; i <= 3; i++) strobe(0, 8'(i), 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (snd_dout !== m2s_q[0]) begin miscompares++; $display("FAIL nmi_head%0d got %h want %h", i, snd_dout, m2s_q[0]); end
      vectors++; if (snd_nmi_b !== 1'b0) begin miscompares++; $display("FAIL nmi_low%0d got %b want 0", i, snd_nmi_b); end
      @(negedge clk); snd_rd_b = 1'b0;
      @(negedge clk); snd_rd_b = 1'b1;
      model_op(3, 8'h00);
      exp_hi = (m2s_q.size() > 0) ? NMI_GAP : 10;
      hi = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (snd_nmi_b === 1'b1) hi++;
        else break;
      end
      vectors++; if (hi !== exp_hi) begin miscompares++; $display("FAIL nmi_gap%0d got %0d want %0d", i, hi, exp_hi); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) strobe(0, 8'h10 + 8'(i), 1);
    vectors++; if (m2s_full !== 1'b1) begin miscompares++; $display("FAIL ovf_full got %b want 1", m2s_full); end
`ifdef SNDMBX_STATUS_EN
    vectors++; if (m2s_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", m2s_ovf); end
    @(negedge clk); stat_clr_b = 1'b0;
    @(negedge clk); stat_clr_b = 1'b1;
    @(negedge clk);
    vectors++; if (m2s_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b want 0", m2s_ovf); end
`endif
    for (int i = 0; i < 4; i++) begin
      vectors++; if (snd_dout !== m2s_q[0]) begin miscompares++; $display("FAIL ovf_drain%0d got %h want %h", i, snd_dout, m2s_q[0]); end
      strobe(3, 8'h00, 2);
    end
    strobe(3, 8'h00, 1);
    vectors++; if ({m2s_empty, snd_dout} !== {1'b1, 8'h13}) begin miscompares++; $display("FAIL unf_hold got %b/%h want 1/13", m2s_empty, snd_dout); end
`ifdef SNDMBX_STATUS_EN
    vectors++; if (m2s_unf !== 1'b1) begin miscompares++; $display("FAIL unf_sticky got %b want 1", m2s_unf); end
`endif
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) strobe(0, 8'h20 + 8'(i), 1);
    vectors++; if (m2s_full !== 1'b1) begin miscompares++; $display("FAIL b2b_full got %b want 1", m2s_full); end
    @(negedge clk); main_din = 8'h77; main_wr_b = 1'b0; snd_rd_b = 1'b0;
    @(negedge clk); main_wr_b = 1'b1; snd_rd_b = 1'b1;
    @(negedge clk);
    model_op(3, 8'h00); model_op(0, 8'h77);
    vectors++; if ({m2s_full, snd_dout} !== {1'b1, m2s_q[0]}) begin miscompares++; $display("FAIL b2b_same got %b/%h want 1/%h", m2s_full, snd_dout, m2s_q[0]); end
`ifdef SNDMBX_STATUS_EN
    vectors++; if (m2s_count !== 3'd4) begin miscompares++; $display("FAIL b2b_count got %0d want 4", m2s_count); end
`endif
    for (int i = 0; i < 4; i++) begin
      vectors++; if (snd_dout !== m2s_q[0]) begin miscompares++; $display("FAIL b2b_drain%0d got %h want %h", i, snd_dout, m2s_q[0]); end
      strobe(3, 8'h00, 1);
    end
    vectors++; if (snd_dout !== 8'h77) begin miscompares++; $display("FAIL b2b_last got %h want 77", snd_dout); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_s2m();
    strobe(1, 8'h3C, 2);
    vectors++; if ({s2m_empty, main_dout} !== {1'b0, 8'h3C}) begin miscompares++; $display("FAIL s2m_push got %b/%h want 0/3c", s2m_empty, main_dout); end
    @(negedge clk);
    vectors++; if (main_int_b !== 1'b0) begin miscompares++; $display("FAIL s2m_int got %b want 0", main_int_b); end
    strobe(2, 8'h00, 1);
    @(negedge clk);
    vectors++; if ({main_int_b, s2m_empty} !== 2'b11) begin miscompares++; $display("FAIL s2m_pop got %b want 11", {main_int_b, s2m_empty}); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      strobe($urandom_range(0, 3), 8'($urandom), $urandom_range(1, 3));
      @(negedge clk);
      vectors++;
      if ({m2s_empty, m2s_full, s2m_empty, s2m_full} !==
          {m2s_q.size() == 0, m2s_q.size() == DEPTH, s2m_q.size() == 0, s2m_q.size() == DEPTH}) begin
        miscompares++;
        $display("FAIL rnd_flags%0d got %b want %b", n, {m2s_empty, m2s_full, s2m_empty, s2m_full},
                 {m2s_q.size() == 0, m2s_q.size() == DEPTH, s2m_q.size() == 0, s2m_q.size() == DEPTH});
      end
      vectors++; if ({snd_dout, main_dout} !== {m2s_last, s2m_last}) begin miscompares++; $display("FAIL rnd_dout%0d got %h/%h want %h/%h", n, snd_dout, main_dout, m2s_last, s2m_last); end
      vectors++; if (main_int_b !== (s2m_q.size() == 0)) begin miscompares++; $display("FAIL rnd_int%0d got %b want %b", n, main_int_b, s2m_q.size() == 0); end
    end
  endtask

  task automatic test_reset_midstrobe();
    while (m2s_q.size() > 0) strobe(3, 8'h00, 1);
    strobe(0, 8'h41, 1); strobe(0, 8'h42, 1);
    @(negedge clk); main_din = 8'h5A; main_wr_b = 1'b0;
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    vectors++; if ({m2s_empty, s2m_empty, m2s_full} !== 3'b110) begin miscompares++; $display("FAIL rst_mid_flags got %b want 110", {m2s_empty, s2m_empty, m2s_full}); end
    vectors++; if ({snd_nmi_b, main_int_b} !== 2'b11) begin miscompares++; $display("FAIL rst_mid_irq got %b want 11", {snd_nmi_b, main_int_b}); end
    m2s_q.delete(); s2m_q.delete(); m2s_last = 8'h00; s2m_last = 8'h00;
    @(negedge clk); rst_b = 1'b1; main_din = 8'h6B;
    repeat (4) @(negedge clk);
    main_wr_b = 1'b1;
    @(negedge clk);
    model_op(0, 8'h6B);
    vectors++; if ({m2s_empty, snd_dout} !== {1'b0, m2s_last}) begin miscompares++; $display("FAIL rst_mid_commit got %b/%h want 0/%h", m2s_empty, snd_dout, m2s_last); end
  endtask

  initial begin
    rst_b = 1'b0;
    main_din = 8'h00; snd_din = 8'h00;
    main_wr_b = 1'b1; main_rd_b = 1'b1; snd_wr_b = 1'b1; snd_rd_b = 1'b1;
`ifdef SNDMBX_STATUS_EN
    stat_clr_b = 1'b1;
`endif
    test_reset();
    test_first_push();
    test_nmi_gap();
    test_overflow();
    test_back_to_back();
    test_s2m();
    test_random();
    test_reset_midstrobe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
